// File: rtl/addsub_seq_16bit.sv
// 16-bit signed add/subtract built from one 4-bit slice iterated over four nibbles.
// Optional saturation on overflow; flags and result publish only when the operation completes.
module addsub_seq_16bit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        sub,
  input  logic        sat,
  output logic        ready,
  output logic        done,
  output logic [15:0] Result,
  output logic        Ovfl,
  output logic        Zero,
  output logic        Neg
);

  // state | meaning
  // IDLE  | waiting for start, ready=1
  // RUN   | one nibble per cycle, cnt 0..3
  // DONE  | result published, done=1, ready=1
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        carry_q, carry_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic        sat_q, sat_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] result_q, result_d;
  logic        ovfl_q, ovfl_d;
  logic        zero_q, zero_d;
  logic        neg_q, neg_d;

  logic [3:0]  a_nib, b_nib, sum_nib, lo_sum;
  logic        c_into_msb, c_out, ovf_now;
  logic [15:0] raw_sum, final_res;

  // The slice splits at its top bit so the last step exposes carry into bit 15.
  always_comb begin
    a_nib      = a_q[{cnt_q, 2'b00} +: 4];
    b_nib      = b_q[{cnt_q, 2'b00} +: 4];
    lo_sum     = {1'b0, a_nib[2:0]} + {1'b0, b_nib[2:0]} + {3'b000, carry_q};
    c_into_msb = lo_sum[3];
    sum_nib    = {a_nib[3] ^ b_nib[3] ^ c_into_msb, lo_sum[2:0]};
    c_out      = (a_nib[3] & b_nib[3]) | (c_into_msb & (a_nib[3] ^ b_nib[3]));
    ovf_now    = c_into_msb ^ c_out;
    raw_sum    = {sum_nib, acc_q[11:0]};
    if (sat_q && ovf_now)
      final_res = a_q[15] ? 16'h8000 : 16'h7FFF;
    else
      final_res = raw_sum;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    sat_d    = sat_q;
    acc_d    = acc_q;
    result_d = result_q;
    ovfl_d   = ovfl_q;
    zero_d   = zero_q;
    neg_d    = neg_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = A;
          b_d     = B ^ {16{sub}};
          sat_d   = sat;
          carry_d = sub;
          cnt_d   = 2'd0;
          state_d = RUN;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        acc_d[{cnt_q, 2'b00} +: 4] = sum_nib;
        carry_d = c_out;
        cnt_d   = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          state_d  = DONE;
          result_d = final_res;
          ovfl_d   = ovf_now;
          zero_d   = (final_res == 16'h0000);
          neg_d    = final_res[15];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 2'd0;
      carry_q  <= 1'b0;
      a_q      <= 16'h0000;
      b_q      <= 16'h0000;
      sat_q    <= 1'b0;
      acc_q    <= 16'h0000;
      result_q <= 16'h0000;
      ovfl_q   <= 1'b0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sat_q    <= sat_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      ovfl_q   <= ovfl_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
    end
  end

  assign ready  = (state_q == IDLE) || (state_q == DONE);
  assign done   = (state_q == DONE);
  assign Result = result_q;
  assign Ovfl   = ovfl_q;
  assign Zero   = zero_q;
  assign Neg    = neg_q;

endmodule

// File: tb/tb_addsub_seq_16bit.sv
// Directed and random bench for addsub_seq_16bit; expected results are queued at
// accept time from an integer reference model and compared when done pulses.
module tb_addsub_seq_16bit;

  logic        clk = 1'b0;
  logic        rst_n, start, sub, sat;
  logic [15:0] A, B;
  logic        ready, done, Ovfl, Zero, Neg;
  logic [15:0] Result;

  typedef struct {
    logic [15:0] res;
    logic        ov;
    logic        z;
    logic        n;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  addsub_seq_16bit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .sub(sub), .sat(sat),
    .ready(ready), .done(done), .Result(Result), .Ovfl(Ovfl), .Zero(Zero), .Neg(Neg)
  );

  initial forever #5 clk = ~clk;

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic s, input logic st);
    exp_t e;
    int   r;
    r = s ? (int'($signed(a)) - int'($signed(b))) : (int'($signed(a)) + int'($signed(b)));
    e.ov  = (r > 32767) || (r < -32768);
    e.res = r[15:0];
    if (st && e.ov) e.res = (r > 0) ? 16'h7FFF : 16'h8000;
    e.z = (e.res == 16'h0000);
    e.n = e.res[15];
    return e;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_result(input string tag);
    exp_t e;
    total++;
    assert (sb.size() > 0) else begin
      bad++;
      $error("FAIL %s_sb_empty observed=0 expected=1", tag);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_result"}, Result, e.res);
      chk({tag, "_ovfl"}, {15'd0, Ovfl}, {15'd0, e.ov});
      chk({tag, "_zero"}, {15'd0, Zero}, {15'd0, e.z});
      chk({tag, "_neg"}, {15'd0, Neg}, {15'd0, e.n});
    end
  endtask

  // One operation with a single-cycle start; operands are scrambled during RUN.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input logic s, input logic st, input string tag);
    int n;
    @(negedge clk);
    A = a; B = b; sub = s; sat = st; start = 1'b1;
    sb.push_back(model(a, b, s, st));
    @(negedge clk);
    start = 1'b0;
    n = 0;
    chk({tag, "_ready_run"}, {15'd0, ready}, 16'd0);
    while (done !== 1'b1 && n < 20) begin
      A = 16'($urandom); B = 16'($urandom); sub = ~sub; sat = ~sat;
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, 16'(n), 16'd4);
    check_result(tag);
    @(negedge clk);
    chk({tag, "_done_pulse"}, {15'd0, done}, 16'd0);
  endtask

  initial begin
    int          n, m, seen;
    logic [15:0] r1;
    rst_n = 1'b0; start = 1'b0; A = 16'h0; B = 16'h0; sub = 1'b0; sat = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {15'd0, ready}, 16'd1);
    chk("rst_done", {15'd0, done}, 16'd0);
    chk("rst_result", Result, 16'h0000);
    chk("rst_flags", {13'd0, Ovfl, Zero, Neg}, 16'd0);
    rst_n = 1'b1;

    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, "pos_ovf_wrap");
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b1, "pos_ovf_sat");
    run_op(16'h8000, 16'h0001, 1'b1, 1'b1, "neg_ovf_sat");
    run_op(16'h8000, 16'h0001, 1'b1, 1'b0, "neg_ovf_wrap");
    run_op(16'h1234, 16'h1234, 1'b1, 1'b0, "sub_zero");
    run_op(16'h00F8, 16'h0009, 1'b0, 1'b0, "nibble_chain");
    run_op(16'h0000, 16'h8000, 1'b1, 1'b1, "sub_min_sat");
    run_op(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, "neg_plus_neg");
    for (int i = 0; i < 16; i++)
      run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), "rand");

    // Back-to-back: start stays high through RUN, second op accepted in DONE.
    @(negedge clk);
    A = 16'h0F0F; B = 16'h00F1; sub = 1'b0; sat = 1'b0; start = 1'b1;
    sb.push_back(model(16'h0F0F, 16'h00F1, 1'b0, 1'b0));
    @(negedge clk);
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      A = 16'($urandom); B = 16'($urandom); sub = ~sub; sat = ~sat;
      @(negedge clk);
      n++;
    end
    chk("b2b_first_latency", 16'(n), 16'd4);
    A = 16'h8000; B = 16'h8000; sub = 1'b0; sat = 1'b1;
    sb.push_back(model(16'h8000, 16'h8000, 1'b0, 1'b1));
    r1 = Result;
    check_result("b2b_first");
    @(negedge clk);
    start = 1'b0;
    m = 1;
    chk("b2b_ready_run", {15'd0, ready}, 16'd0);
    while (done !== 1'b1 && m < 20) begin
      if (m == 3) chk("b2b_result_hold", Result, r1);
      @(negedge clk);
      m++;
    end
    chk("b2b_spacing", 16'(m), 16'd5);
    check_result("b2b_second");

    // Abort mid-RUN with reset while the third nibble is pending.
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, "pre_abort");
    @(negedge clk);
    A = 16'h1111; B = 16'h2222; sub = 1'b0; sat = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_ready", {15'd0, ready}, 16'd1);
    chk("abort_result", Result, 16'h0000);
    chk("abort_flags", {13'd0, Ovfl, Zero, Neg}, 16'd0);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (done === 1'b1) seen++;
      @(negedge clk);
    end
    chk("abort_no_done", 16'(seen), 16'd0);
    run_op(16'h4000, 16'hC000, 1'b1, 1'b1, "after_abort");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
